// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - state, opcode, ALU_Op and mux encodings shared with datapath and ALU control
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_EXEC_R    = 4'd6,
        ST_EXEC_I    = 4'd7,
        ST_ALU_WB    = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_EXEC_LUI  = 4'd10,
        ST_TRAP      = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_FUNCT  = 3'b000;
    localparam logic [2:0] ALU_BRANCH = 3'b001;
    localparam logic [2:0] ALU_LUI    = 3'b010;
    localparam logic [2:0] ALU_ADD    = 3'b011;

    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLD_PC = 2'b01;
    localparam logic [1:0] SRCA_RS1    = 2'b10;

    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEM     = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] result_src;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control <-> datapath bundle; illegal_o exists only with ILLEGAL_OPCODE_TRAP_EN
interface multicycle_control_if;
    logic [6:0] opcode_i;
    logic       mem_ready_i;
    logic       ir_write_o;
    logic       pc_write_o;
    logic       pc_write_cond_o;
    logic       mem_read_o;
    logic       mem_write_o;
    logic       reg_write_o;
    logic [1:0] alu_src_a_o;
    logic [1:0] alu_src_b_o;
    logic [2:0] alu_op_o;
    logic [1:0] result_src_o;
    logic [3:0] state_o;
`ifdef ILLEGAL_OPCODE_TRAP_EN
    logic       illegal_o;

    modport ctrl (
        input  opcode_i, mem_ready_i,
        output ir_write_o, pc_write_o, pc_write_cond_o, mem_read_o, mem_write_o,
               reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o,
               state_o, illegal_o
    );
    modport dp (
        output opcode_i, mem_ready_i,
        input  ir_write_o, pc_write_o, pc_write_cond_o, mem_read_o, mem_write_o,
               reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o,
               state_o, illegal_o
    );
`else
    modport ctrl (
        input  opcode_i, mem_ready_i,
        output ir_write_o, pc_write_o, pc_write_cond_o, mem_read_o, mem_write_o,
               reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o,
               state_o
    );
    modport dp (
        output opcode_i, mem_ready_i,
        input  ir_write_o, pc_write_o, pc_write_cond_o, mem_read_o, mem_write_o,
               reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o,
               state_o
    );
`endif
endinterface

// File: rtl/multicycle_control_decode.sv
// rtl/multicycle_control_decode.sv - combinational state -> control vector decode
module multicycle_control_decode
    import multicycle_control_pkg::*;
(
    input  state_t i_state,
    input  logic   i_mem_ready,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            ST_FETCH: begin
                // IR and PC+4 land on the same edge the memory completes
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
                o_ctrl.alu_src_a = SRCA_PC;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALU_ADD;
            end
            ST_DECODE: begin
                o_ctrl.alu_src_a = SRCA_OLD_PC;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALU_ADD;
            end
            ST_MEM_ADDR: begin
                o_ctrl.alu_src_a = SRCA_RS1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALU_ADD;
            end
            ST_MEM_READ:  o_ctrl.mem_read = 1'b1;
            ST_MEM_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.result_src = RES_MEM;
            end
            ST_MEM_WRITE: o_ctrl.mem_write = 1'b1;
            ST_EXEC_R: begin
                o_ctrl.alu_src_a = SRCA_RS1;
                o_ctrl.alu_src_b = SRCB_RS2;
                o_ctrl.alu_op    = ALU_FUNCT;
            end
            ST_EXEC_I: begin
                o_ctrl.alu_src_a = SRCA_RS1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALU_FUNCT;
            end
            ST_EXEC_LUI: begin
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALU_LUI;
            end
            ST_ALU_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.result_src = RES_ALUOUT;
            end
            ST_BRANCH: begin
                o_ctrl.alu_src_a     = SRCA_RS1;
                o_ctrl.alu_src_b     = SRCB_RS2;
                o_ctrl.alu_op        = ALU_BRANCH;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.result_src    = RES_ALUOUT;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle sequencing FSM; ILLEGAL_OPCODE_TRAP_EN enables the TRAP state and illegal_o
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
)(
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.ctrl   bus
);

    state_t r_state;
    state_t w_next;
    ctrl_t  w_ctrl;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= state_t'(RESET_STATE);
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH:    if (bus.mem_ready_i) w_next = ST_DECODE;
            ST_DECODE: begin
                case (bus.opcode_i)
                    OP_LOAD, OP_STORE: w_next = ST_MEM_ADDR;
                    OP_RTYPE:          w_next = ST_EXEC_R;
                    OP_ITYPE:          w_next = ST_EXEC_I;
                    OP_BRANCH:         w_next = ST_BRANCH;
                    OP_LUI:            w_next = ST_EXEC_LUI;
`ifdef ILLEGAL_OPCODE_TRAP_EN
                    default:           w_next = ST_TRAP;
`else
                    default:           w_next = ST_FETCH;
`endif
                endcase
            end
            ST_MEM_ADDR:  w_next = (bus.opcode_i == OP_LOAD) ? ST_MEM_READ : ST_MEM_WRITE;
            ST_MEM_READ:  if (bus.mem_ready_i) w_next = ST_MEM_WB;
            ST_MEM_WRITE: if (bus.mem_ready_i) w_next = ST_FETCH;
            ST_EXEC_R, ST_EXEC_I, ST_EXEC_LUI: w_next = ST_ALU_WB;
            ST_MEM_WB, ST_ALU_WB, ST_BRANCH:   w_next = ST_FETCH;
`ifdef ILLEGAL_OPCODE_TRAP_EN
            ST_TRAP:      w_next = ST_TRAP;
`endif
            default:      w_next = ST_FETCH;
        endcase
    end

    multicycle_control_decode u_decode (
        .i_state     (r_state),
        .i_mem_ready (bus.mem_ready_i),
        .o_ctrl      (w_ctrl)
    );

    assign bus.ir_write_o      = w_ctrl.ir_write;
    assign bus.pc_write_o      = w_ctrl.pc_write;
    assign bus.pc_write_cond_o = w_ctrl.pc_write_cond;
    assign bus.mem_read_o      = w_ctrl.mem_read;
    assign bus.mem_write_o     = w_ctrl.mem_write;
    assign bus.reg_write_o     = w_ctrl.reg_write;
    assign bus.alu_src_a_o     = w_ctrl.alu_src_a;
    assign bus.alu_src_b_o     = w_ctrl.alu_src_b;
    assign bus.alu_op_o        = w_ctrl.alu_op;
    assign bus.result_src_o    = w_ctrl.result_src;
    assign bus.state_o         = r_state;
`ifdef ILLEGAL_OPCODE_TRAP_EN
    assign bus.illegal_o       = (r_state == ST_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed and randomized instruction sequences checked against a phase-list model
module tb_multicycle_control;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    multicycle_control_if bus();

    multicycle_control #(.RESET_STATE(4'd0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RR  = 7'b0110011;
    localparam logic [6:0] II  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] LU  = 7'b0110111;
    localparam logic [6:0] BAD = 7'b1111111;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // {ir, pc, pc_cond, mem_rd, mem_wr, reg_wr, src_a, src_b, alu_op, result_src}
    function automatic logic [14:0] obs_ctrl();
        return {bus.ir_write_o, bus.pc_write_o, bus.pc_write_cond_o, bus.mem_read_o,
                bus.mem_write_o, bus.reg_write_o, bus.alu_src_a_o, bus.alu_src_b_o,
                bus.alu_op_o, bus.result_src_o};
    endfunction

    function automatic logic [14:0] exp_ctrl(input int s, input logic rdy);
        case (s)
            0:  return {rdy, rdy, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 3'b011, 2'b00};
            1:  return {6'b000000, 2'b01, 2'b01, 3'b011, 2'b00};
            2:  return {6'b000000, 2'b10, 2'b01, 3'b011, 2'b00};
            3:  return {6'b000100, 4'b0000, 3'b000, 2'b00};
            4:  return {6'b000001, 4'b0000, 3'b000, 2'b01};
            5:  return {6'b000010, 4'b0000, 3'b000, 2'b00};
            6:  return {6'b000000, 2'b10, 2'b00, 3'b000, 2'b00};
            7:  return {6'b000000, 2'b10, 2'b01, 3'b000, 2'b00};
            8:  return {6'b000001, 4'b0000, 3'b000, 2'b00};
            9:  return {6'b001000, 2'b10, 2'b00, 3'b001, 2'b00};
            10: return {6'b000000, 2'b00, 2'b01, 3'b010, 2'b00};
            default: return 15'd0;
        endcase
    endfunction

    // One instruction as a list of (phase, mem_ready) pairs; wf/wm are wait cycles
    // on the fetch and on the data access. Expects to start at posedge+1 in FETCH.
    task automatic run_instr(input logic [6:0] op, input int wf, input int wm, input string name);
        int   seq[$];
        logic rdy[$];
        repeat (wf) begin seq.push_back(0); rdy.push_back(1'b0); end
        seq.push_back(0); rdy.push_back(1'b1);
        seq.push_back(1); rdy.push_back(1'($urandom));
        case (op)
            LD: begin
                seq.push_back(2); rdy.push_back(1'($urandom));
                repeat (wm) begin seq.push_back(3); rdy.push_back(1'b0); end
                seq.push_back(3); rdy.push_back(1'b1);
                seq.push_back(4); rdy.push_back(1'($urandom));
            end
            SW: begin
                seq.push_back(2); rdy.push_back(1'($urandom));
                repeat (wm) begin seq.push_back(5); rdy.push_back(1'b0); end
                seq.push_back(5); rdy.push_back(1'b1);
            end
            RR: begin seq.push_back(6);  rdy.push_back(1'($urandom)); seq.push_back(8); rdy.push_back(1'($urandom)); end
            II: begin seq.push_back(7);  rdy.push_back(1'($urandom)); seq.push_back(8); rdy.push_back(1'($urandom)); end
            LU: begin seq.push_back(10); rdy.push_back(1'($urandom)); seq.push_back(8); rdy.push_back(1'($urandom)); end
            BR: begin seq.push_back(9);  rdy.push_back(1'($urandom)); end
`ifdef ILLEGAL_OPCODE_TRAP_EN
            default: repeat (3) begin seq.push_back(11); rdy.push_back(1'($urandom)); end
`else
            default: ;
`endif
        endcase
        bus.opcode_i = op;
        foreach (seq[i]) begin
            bus.mem_ready_i = rdy[i];
            #2;
            check({name, "_state"}, 32'(bus.state_o), 32'(seq[i]));
            check({name, "_ctrl"},  32'(obs_ctrl()), 32'(exp_ctrl(seq[i], rdy[i])));
`ifdef ILLEGAL_OPCODE_TRAP_EN
            check({name, "_illegal"}, 32'(bus.illegal_o), 32'(seq[i] == 11));
`endif
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [6:0] ops [6];
        ops = '{LD, SW, RR, II, BR, LU};

        // reset held 3 cycles with memory ready
        reset = 1'b0;
        bus.mem_ready_i = 1'b1;
        bus.opcode_i = RR;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 32'(bus.state_o), 32'd0);
        check("rst_ctrl",  32'(obs_ctrl()), 32'(exp_ctrl(0, 1'b1)));
`ifdef ILLEGAL_OPCODE_TRAP_EN
        check("rst_illegal", 32'(bus.illegal_o), 32'd0);
`endif
        reset = 1'b1;
        #2 check("rel_state", 32'(bus.state_o), 32'd0);
        @(posedge clk); #1 check("rel_decode", 32'(bus.state_o), 32'd1);
        @(posedge clk); #1 check("rel_exec_r", 32'(bus.state_o), 32'd6);
        @(posedge clk); #1 check("rel_alu_wb", 32'(bus.state_o), 32'd8);
        @(posedge clk); #1 check("rel_fetch",  32'(bus.state_o), 32'd0);

        // directed instruction shapes
        run_instr(RR, 0, 0, "rtype");
        run_instr(LD, 0, 2, "load_w2");
        run_instr(BR, 0, 0, "branch");
        run_instr(LU, 0, 0, "lui");
        run_instr(SW, 1, 0, "store_wf1");
        run_instr(II, 0, 0, "itype");
`ifndef ILLEGAL_OPCODE_TRAP_EN
        run_instr(BAD, 0, 0, "bad_nop");
`endif

        // randomized instruction stream
        for (int k = 0; k < 30; k++)
            run_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 3), "rand");

        // async reset during a stalled store
        bus.opcode_i = SW;
        bus.mem_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.mem_ready_i = 1'b0;
        #2 check("sw_wait_state", 32'(bus.state_o), 32'd5);
        check("sw_wait_wr", 32'(bus.mem_write_o), 32'd1);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check("arst_state", 32'(bus.state_o), 32'd0);
        check("arst_wr",    32'(bus.mem_write_o), 32'd0);
        check("arst_rd",    32'(bus.mem_read_o), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        bus.mem_ready_i = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("post_arst_fetch", 32'(bus.state_o), 32'd0);

`ifdef ILLEGAL_OPCODE_TRAP_EN
        run_instr(BAD, 0, 0, "trap");
        check("trap_hold", 32'(bus.state_o), 32'd11);
        reset = 1'b0;
        #1 check("trap_exit", 32'(bus.state_o), 32'd0);
        @(posedge clk); #1 reset = 1'b1;
`endif
        run_instr(RR, 0, 0, "final");
        #2 check("final_fetch", 32'(bus.state_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle sequencing FSM that drives the shared datapath (PC, instruction register, register file, single ALU, unified memory) one phase per clock. It decodes the 7-bit opcode held in the instruction register and issues the per-phase mux selects, write strobes and the 3-bit ALU_Op consumed by the ALU control unit, so one ALU serves PC increment, address generation, branch compare and arithmetic. It sits between the instruction register and the datapath muxes and replaces the single-cycle combinational control.

## Interface
Parameters:
- RESET_STATE, 4'd0 (FETCH), state entered on reset

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- opcode_i  in  7  instruction bits [6:0] from instruction register
- mem_ready_i  in  1  memory handshake: access completes on the edge where it is high
- ir_write_o  out  1  load instruction register
- pc_write_o  out  1  unconditional PC load
- pc_write_cond_o  out  1  PC load qualified by ALU branch result in datapath
- mem_read_o  out  1  memory read request
- mem_write_o  out  1  memory write request
- reg_write_o  out  1  register file write enable
- alu_src_a_o  out  2  00 PC, 01 old PC, 10 rs1
- alu_src_b_o  out  2  00 rs2, 01 immediate, 10 constant 4
- alu_op_o  out  3  000 funct-decoded arithmetic, 001 branch compare, 010 LUI, 011 forced ADD
- result_src_o  out  2  00 ALUOut register, 01 memory data, 10 ALU result
- state_o  out  4  current state encoding
- illegal_o  out  1  present only with ILLEGAL_OPCODE_TRAP_EN

## Operation
- States (encoding): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, EXEC_I 7, ALU_WB 8, BRANCH 9, EXEC_LUI 10, TRAP 11.
- FETCH: mem_read_o=1, A=00, B=10, alu_op=011; ir_write_o=pc_write_o=mem_ready_i; stays until mem_ready_i=1, then DECODE.
- DECODE: A=01, B=01, alu_op=011 (branch target into ALUOut). Next by opcode: 0000011/0100011 -> MEM_ADDR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH; 0110111 -> EXEC_LUI; other -> TRAP/FETCH (see Configuration).
- MEM_ADDR: A=10, B=01, alu_op=011; next MEM_READ if opcode_i=0000011 else MEM_WRITE.
- MEM_READ: mem_read_o=1 until mem_ready_i, then MEM_WB. MEM_WB: reg_write_o=1, result_src=01 -> FETCH.
- MEM_WRITE: mem_write_o=1 until mem_ready_i, then FETCH.
- EXEC_R: A=10, B=00, alu_op=000 -> ALU_WB. EXEC_I: A=10, B=01, alu_op=000 -> ALU_WB. EXEC_LUI: B=01, alu_op=010 -> ALU_WB.
- ALU_WB: reg_write_o=1, result_src=00 -> FETCH.
- BRANCH: A=10, B=00, alu_op=001, pc_write_cond_o=1, result_src=00 -> FETCH.
- Every output not listed for a state is 0. opcode_i is sampled only in DECODE and MEM_ADDR; IR is stable there.

## Timing
- State register updates on rising clk; all outputs are combinational decode of state (plus mem_ready_i for FETCH strobes).
- Zero-wait latency (mem_ready_i tied 1): R/I/LUI 4 cycles, load 5, store 4, branch 3. Each wait cycle adds one.
- Request held stable while mem_ready_i=0; mem_ready_i outside FETCH/MEM_READ/MEM_WRITE is ignored.
- Reset (reset=0, async): state -> FETCH immediately; outputs read FETCH values: mem_read_o=1, alu_src_a_o=00, alu_src_b_o=10, alu_op_o=011, ir_write_o=pc_write_o=mem_ready_i, all others 0, state_o=0, illegal_o=0. Reset mid-access abandons the access; no write strobe survives the reset edge.
- Deassertion: first FETCH phase starts on the first rising clk after reset=1.

## Configuration
- ILLEGAL_OPCODE_TRAP_EN defined: unknown opcode in DECODE -> TRAP; TRAP holds all strobes 0, illegal_o=1, exits only by reset.
- Undefined: unknown opcode -> FETCH (executes as a NOP, PC already advanced); TRAP state and illegal_o port absent.

## Structure
- Shared package: state encodings, opcode constants, ALU_Op codes (including forced-ADD 011), src-A/src-B/result-src mux encodings — shared with datapath and ALU control.
- One sub-module natural: multicycle_control_decode (state -> output vector, combinational); FSM next-state and register stay in top.

## Test plan
- Reset held low 3 cycles with mem_ready_i=1 -> state_o=0, mem_read_o=1, reg_write_o=0, mem_write_o=0; release -> DECODE next edge.
- R-type 0110011, mem_ready_i=1 -> states 0,1,6,8,0; alu_op_o=000 in EXEC_R; reg_write_o high exactly 1 cycle.
- Load 0000011 with 2 wait cycles in MEM_READ -> states 0,1,2,3,3,3,4,0; mem_read_o high 3 cycles in MEM_READ.
- Branch 1100011 -> states 0,1,9,0; pc_write_cond_o=1 and alu_op_o=001 only in BRANCH.
- LUI 0110111 -> EXEC_LUI with alu_op_o=010, alu_src_b_o=01; opcode 1111111 -> TRAP with illegal_o=1 (macro on) or FETCH next (macro off).
- reset pulsed low during MEM_WRITE wait -> state_o=0 asynchronously, mem_write_o drops same cycle.
